// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: framer state encoding, sync default and opcodes shared with the SD controller
package uart_cmd_pkg;
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_OPC,
    ST_ARG,
    ST_CHK,
    ST_HOLD
  } state_t;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_STATUS = 8'h53;
endpackage

// File: rtl/uart_cmd_framer_if.sv
// uart_cmd_framer_if: received-byte strobe in, validated command out over valid/ready
interface uart_cmd_framer_if;
  logic rx_done_tick;
  logic [7:0] rx_data;
  logic cmd_valid;
  logic [7:0] cmd_op;
  logic [31:0] cmd_arg;
  logic cmd_ready;
  modport master (
    input rx_done_tick,
    input rx_data,
    input cmd_ready,
    output cmd_valid,
    output cmd_op,
    output cmd_arg
  );
  modport slave (
    output rx_done_tick,
    output rx_data,
    output cmd_ready,
    input cmd_valid,
    input cmd_op,
    input cmd_arg
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: hunts for SYNC, assembles 7-byte XOR-checked frames, hands off op/arg
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic clk,
  input logic rst,
  uart_cmd_framer_if.master bus,
  output logic err_chk,
  output logic err_timeout,
  output logic err_overrun,
  output logic busy
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  // timeout fires in the cycle the counter would step onto TIMEOUT_CYC-1
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] op_q, op_d;
  logic [31:0] arg_q, arg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_chk_q, err_chk_d;
  logic err_timeout_q, err_timeout_d;
  logic err_overrun_q, err_overrun_d;
  logic rx;
  logic [7:0] data;
  logic framing;
  assign rx = bus.rx_done_tick;
  assign data = bus.rx_data;
  assign framing = state_q inside {ST_OPC, ST_ARG, ST_CHK};
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    chk_d = chk_q;
    op_d = op_q;
    arg_d = arg_q;
    cnt_d = '0;
    err_chk_d = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    case (state_q)
      ST_HUNT: state_d = (rx && data == SYNC_BYTE) ? ST_OPC : ST_HUNT;
      ST_OPC: if (rx) begin
        op_d = data;
        chk_d = data;
        idx_d = '0;
        state_d = ST_ARG;
      end
      ST_ARG: if (rx) begin
        arg_d = {arg_q[23:0], data};
        chk_d = chk_q ^ data;
        idx_d = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? ST_CHK : ST_ARG;
      end
      ST_CHK: if (rx) begin
        state_d = (data == chk_q) ? ST_HOLD : ST_HUNT;
        err_chk_d = data != chk_q;
      end
      ST_HOLD: begin
        err_overrun_d = rx;
        state_d = bus.cmd_ready ? ST_HUNT : ST_HOLD;
      end
      default: state_d = ST_HUNT;
    endcase
    if (framing) begin
      cnt_d = rx ? '0 : cnt_q + CW'(1);
      if (!rx && cnt_q == CNT_LAST) begin
        state_d = ST_HUNT;
        err_timeout_d = 1'b1;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      idx_q <= '0;
      chk_q <= '0;
      op_q <= '0;
      arg_q <= '0;
      cnt_q <= '0;
      err_chk_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
      op_q <= op_d;
      arg_q <= arg_d;
      cnt_q <= cnt_d;
      err_chk_q <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end
  assign bus.cmd_valid = state_q == ST_HOLD;
  assign bus.cmd_op = op_q;
  assign bus.cmd_arg = arg_q;
  assign busy = state_q != ST_HUNT;
  assign err_chk = err_chk_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed frames checked against a queue-based frame model every cycle
module tb_uart_cmd_framer;
  import uart_cmd_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  logic err_chk, err_timeout, err_overrun, busy;
  uart_cmd_framer_if bus ();
  uart_cmd_framer #(.TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_chk(err_chk),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy(busy)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errs = 0;
  int n_valid, n_chk, n_to, n_ov;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0] frm[$];
  int gap = 0;
  bit hold = 0;
  bit m_chk = 0, m_to = 0, m_ov = 0;
  logic [7:0] m_op = '0;
  logic [31:0] m_arg = '0;
  logic [7:0] x;
  // model: a frame is the queue of bytes collected since SYNC; outcome decided once it holds 7
  always @(posedge clk) begin
    m_chk = 0;
    m_to = 0;
    m_ov = 0;
    if (rst) begin
      frm.delete();
      hold = 0;
      gap = 0;
      m_op = '0;
      m_arg = '0;
    end else if (hold) begin
      m_ov = bus.rx_done_tick;
      if (bus.cmd_ready) hold = 0;
    end else if (frm.size() == 0) begin
      if (bus.rx_done_tick && bus.rx_data == 8'hA5) begin
        frm.push_back(bus.rx_data);
        gap = 0;
      end
    end else if (bus.rx_done_tick) begin
      frm.push_back(bus.rx_data);
      gap = 0;
      if (frm.size() == 7) begin
        x = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
        if (x == frm[6]) begin
          hold = 1;
          m_op = frm[1];
          m_arg = {frm[2], frm[3], frm[4], frm[5]};
        end else m_chk = 1;
        frm.delete();
      end
    end else begin
      gap++;
      if (gap == TO - 1) begin
        m_to = 1;
        frm.delete();
      end
    end
  end
  always @(negedge clk) begin
    check("valid", {31'd0, bus.cmd_valid}, {31'd0, hold});
    check("busy", {31'd0, busy}, {31'd0, hold || frm.size() > 0});
    check("err_chk", {31'd0, err_chk}, {31'd0, m_chk});
    check("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
    check("err_overrun", {31'd0, err_overrun}, {31'd0, m_ov});
    check("one_err", {30'd0, 2'(err_chk + err_timeout + err_overrun) > 2'd1}, 32'd0);
    if (hold) begin
      check("cmd_op", {24'd0, bus.cmd_op}, {24'd0, m_op});
      check("cmd_arg", bus.cmd_arg, m_arg);
    end
    n_valid += int'(bus.cmd_valid);
    n_chk += int'(err_chk);
    n_to += int'(err_timeout);
    n_ov += int'(err_overrun);
  end
  task automatic put(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data = b;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data = 8'h00;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    n_valid = 0;
    n_chk = 0;
    n_to = 0;
    n_ov = 0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_op"}, {24'd0, bus.cmd_op}, 32'd0);
    check({tag, "_arg"}, bus.cmd_arg, 32'd0);
    check({tag, "_errs"}, {29'd0, err_chk, err_timeout, err_overrun}, 32'd0);
  endtask
  initial begin
    clr();
    rst = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data = 8'h00;
    bus.cmd_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    check_reset_outputs("reset");
    // good frame, consumer ready
    bus.cmd_ready = 1'b1;
    clr();
    put(8'hA5); put(OP_READ); put(8'h00); put(8'h00); put(8'h00); put(8'h10); put(8'h42);
    check("t1_valid", {31'd0, bus.cmd_valid}, 32'd1);
    check("t1_op", {24'd0, bus.cmd_op}, 32'h52);
    check("t1_arg", bus.cmd_arg, 32'h0000_0010);
    idle(2);
    check("t1_valid_cycles", n_valid, 1);
    check("t1_err_pulses", n_chk + n_to + n_ov, 0);
    // bad checksum then a good frame
    clr();
    put(8'hA5); put(OP_WRITE); put(8'h12); put(8'h34); put(8'h56); put(8'h78); put(8'h00);
    check("t2_err_chk", {31'd0, err_chk}, 32'd1);
    check("t2_valid", {31'd0, bus.cmd_valid}, 32'd0);
    idle(1);
    put(8'hA5); put(OP_WRITE); put(8'h12); put(8'h34); put(8'h56); put(8'h78); put(8'h5F);
    check("t2_good_op", {24'd0, bus.cmd_op}, 32'h57);
    check("t2_good_arg", bus.cmd_arg, 32'h1234_5678);
    idle(2);
    check("t2_chk_pulses", n_chk, 1);
    check("t2_valid_cycles", n_valid, 1);
    // garbage before sync, SYNC value inside the argument
    clr();
    put(8'h00); put(8'hFF); put(8'hA5); put(OP_STATUS); put(8'hA5); put(8'h00); put(8'h00); put(8'h01); put(8'hF7);
    check("t3_op", {24'd0, bus.cmd_op}, 32'h53);
    check("t3_arg", bus.cmd_arg, 32'hA500_0001);
    idle(2);
    check("t3_valid_cycles", n_valid, 1);
    // timeout after two bytes
    clr();
    put(8'hA5); put(OP_READ);
    idle(20);
    check("t4_timeouts", n_to, 1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    // byte exactly on cycle 15 after the last one keeps the frame alive
    clr();
    put(8'hA5); put(OP_READ);
    idle(14);
    put(8'h00); put(8'h00); put(8'h00); put(8'h00); put(8'h52);
    check("t4b_valid", {31'd0, bus.cmd_valid}, 32'd1);
    idle(2);
    check("t4b_timeouts", n_to, 0);
    // backpressure with overrun bytes
    clr();
    bus.cmd_ready = 1'b0;
    put(8'hA5); put(OP_READ); put(8'h00); put(8'h00); put(8'h00); put(8'h10); put(8'h42);
    idle(10); put(8'hA5); idle(20); put(8'h33); idle(17);
    check("t5_overruns", n_ov, 2);
    check("t5_valid", {31'd0, bus.cmd_valid}, 32'd1);
    check("t5_op", {24'd0, bus.cmd_op}, 32'h52);
    check("t5_arg", bus.cmd_arg, 32'h0000_0010);
    bus.cmd_ready = 1'b1;
    idle(1);
    check("t5_valid_fall", {31'd0, bus.cmd_valid}, 32'd0);
    // byte on the handshake cycle is dropped as overrun, not taken as SYNC
    clr();
    bus.cmd_ready = 1'b0;
    put(8'hA5); put(OP_STATUS); put(8'h00); put(8'h00); put(8'h00); put(8'h00); put(8'h53);
    idle(3);
    bus.cmd_ready = 1'b1;
    put(8'hA5);
    check("t5b_overrun", {31'd0, err_overrun}, 32'd1);
    check("t5b_busy", {31'd0, busy}, 32'd0);
    idle(2);
    // reset mid-frame
    clr();
    put(8'hA5); put(OP_READ); put(8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_outputs("t6");
    put(8'hA5); put(OP_READ); put(8'h00); put(8'h00); put(8'h00); put(8'h10); put(8'h42);
    check("t6_valid", {31'd0, bus.cmd_valid}, 32'd1);
    check("t6_arg", bus.cmd_arg, 32'h0000_0010);
    idle(3);
    check("t6_err_pulses", n_chk + n_to + n_ov, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Byte-level command framer that sits directly behind the UART receiver. It consumes received bytes (`rx_done_tick` and the data byte), hunts for a sync byte and assembles fixed-length 7-byte frames. Each frame is checked with an XOR checksum. A validated opcode and 32-bit argument go to the SD-card test controller over a valid/ready handshake. Malformed, stalled or overrunning traffic is reported on single-cycle error pulses.

## Interface
- `TIMEOUT_CYC`, default 1_000_000: inter-byte timeout in clk cycles, active only mid-frame; legal range ≥ 2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high; one clock, and reset is synchronous and active-high.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte, valid only when `rx_done_tick` = 1.
- `cmd_valid`  out  1  command available; held until accepted.
- `cmd_op`  out  8  opcode; stable while `cmd_valid` = 1.
- `cmd_arg`  out  32  argument, big-endian from the wire; stable while `cmd_valid` = 1.
- `cmd_ready`  in  1  consumer accepts when `cmd_valid & cmd_ready`.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: mid-frame inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse: byte dropped while holding a command.
- `busy`  out  1  high in every state except HUNT.

## Operation
- Frame format: SYNC, OP, A3, A2, A1, A0, CHK, with CHK = OP ^ A3 ^ A2 ^ A1 ^ A0.
- States:
  - HUNT: a byte equal to SYNC_BYTE moves to OPC; any other byte is discarded silently.
  - OPC: the byte is latched as the opcode and `chk` ← byte. Go to ARG with `idx` = 0.
  - ARG: the byte is shifted into `arg` (MSB first) and `chk` ^= byte. After the 4th byte (`idx` = 3), go to CHK.
  - CHK: if byte == `chk`, go to HOLD. Otherwise pulse `err_chk` and go to HUNT.
  - HOLD: `cmd_valid` = 1. On `cmd_ready`, go to HUNT. Any `rx_done_tick` in HOLD, including the handshake cycle, drops the byte and pulses `err_overrun`.
- Bytes equal to SYNC_BYTE after OPC are ordinary data. There is no mid-frame resync.
- Timeout counter:
  - Cleared on entry to OPC and on every accepted byte in OPC, ARG or CHK.
  - Increments each clk in those three states.
  - On reaching TIMEOUT_CYC-1 with no byte that cycle: pulse `err_timeout` and go to HUNT.
  - If a byte arrives in the same cycle, the byte wins: it is processed and the counter is cleared.
- The counter does not run in HUNT or HOLD. Its width is $clog2(TIMEOUT_CYC).
- `cmd_op` and `cmd_arg` are driven from the holding registers. Their values outside HOLD are don't-care, but they must not change while `cmd_valid` = 1.
- At most one error pulse is asserted per cycle.

## Timing
- Reset values:
  - state = HUNT.
  - `cmd_valid`, `busy`, `err_*` = 0.
  - `cmd_op` = 0, `cmd_arg` = 0, counters = 0.
- Reset mid-frame or in HOLD abandons the frame with no error pulse.
- Latency:
  - `cmd_valid` rises on the clock after the cycle in which the CHK byte's `rx_done_tick` is sampled.
  - `err_chk` pulses in that same following cycle.
- `cmd_valid` falls on the clock after the `cmd_valid & cmd_ready` cycle. A new SYNC byte is accepted from that next cycle on.
- `err_timeout` is registered and asserts the cycle after the counter hits TIMEOUT_CYC-1.
- Back-to-back bytes on consecutive cycles must be handled. The framer never stalls the receiver.

## Structure
- Shared package/include `uart_cmd_pkg` holds:
  - the state encoding;
  - the SYNC_BYTE default;
  - the opcode constants OP_READ = 8'h52, OP_WRITE = 8'h57, OP_STATUS = 8'h53, which the SD controller also uses.
- Single module. The FSM, byte index, checksum accumulator and timeout counter are inline; no sub-module is warranted.
- The framer does not decode opcodes. Unknown opcodes pass through to the consumer.

## Test plan
- Good frame: A5 52 00 00 00 10 42 with `cmd_ready` = 1 → one-cycle `cmd_valid` with `cmd_op` = 52 and `cmd_arg` = 0000_0010; no error pulses.
- Bad checksum: A5 57 12 34 56 78 00 → `err_chk` pulse one cycle after the last byte; `cmd_valid` stays 0. A following good frame is accepted.
- Garbage before sync, plus a sync inside the argument: 00 FF A5 53 A5 00 00 01 F7 → `cmd_op` = 53, `cmd_arg` = A500_0001 (checksum 53^A5^00^00^01 = F7).
- Timeout with TIMEOUT_CYC = 16: A5 52, then 20 idle cycles → `err_timeout` pulses once and `busy` drops. A byte on exactly cycle 15 after the last byte instead continues the frame.
- Backpressure: good frame with `cmd_ready` = 0 for 50 cycles while 2 bytes arrive → 2 `err_overrun` pulses; `cmd_op`/`cmd_arg` stable; handshake completes when `cmd_ready` = 1.
- Reset mid-frame: assert `rst` after A5 52 00 → all outputs return to reset values. The next full good frame is accepted normally.
